// File: rtl/wb_copy_master_pkg.sv
// ---------------------------------------------------------------------------
// wb_copy_master_pkg
// Shared definitions for the Wishbone word-copy engine: the FSM state
// encoding, the bus word size, the full byte-select value and the default
// ack-wait limit used by the optional timeout counter.
// ---------------------------------------------------------------------------
package wb_copy_master_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD,
    ST_WR,
    ST_DONE,
    ST_ERR
  } state_e;

  localparam logic [31:0] WORD_BYTES      = 32'd4;
  localparam logic [3:0]  SEL_ALL         = 4'hF;
  localparam int          DEFAULT_TIMEOUT = 255;

endpackage

// File: rtl/wb_copy_timer.sv
// ---------------------------------------------------------------------------
// wb_copy_timer
// Counts consecutive cycles in which a Wishbone cycle is outstanding without
// an ack. expired is high in the TIMEOUT_CYC-th such cycle, so the master can
// drop cyc/stb on that edge. Any cycle without run restarts the count.
//
// Ports:
//   clk      in   clock, rising edge
//   rst_n    in   asynchronous active-low reset
//   run      in   bus cycle outstanding and not acked this cycle
//   expired  out  limit reached in the current cycle
// ---------------------------------------------------------------------------
module wb_copy_timer #(
  parameter int TIMEOUT_CYC = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run,
  output logic expired
);

  // 8-bit counter: the first waiting cycle is count 0.
  localparam logic [7:0] LIMIT = 8'(TIMEOUT_CYC - 1);

  logic [7:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (run && (cnt != LIMIT)) begin
      cnt <= cnt + 8'd1;
    end else begin
      cnt <= '0;
    end
  end

  assign expired = run && (cnt == LIMIT);

endmodule

// File: rtl/wb_copy_master.sv
// ---------------------------------------------------------------------------
// wb_copy_master
// Copies len_i 32-bit words from src_adr_i to dst_adr_i using classic
// single Wishbone read/write cycles. Each bus cycle is preceded by one
// cycle with cyc/stb low, so a word costs 4 cycles when the slave acks in
// the first stb cycle; done_o follows one cycle after the DONE state.
//
// Optional feature: define WB_COPY_TIMEOUT_EN to abort a copy when ack is
// missing for TIMEOUT_CYC consecutive cycles (sets sticky err_o). Without
// it the master waits forever for ack and err_o is constant 0.
//
// Ports:
//   wb_clk_i, wb_rst_ni       clock / asynchronous active-low reset
//   start_i                   start request (honoured only in IDLE)
//   src_adr_i, dst_adr_i      source / destination byte addresses
//   len_i                     word count (0 = complete without bus traffic)
//   busy_o, done_o, err_o     status: running, completion pulse, timeout
//   wbm_*                     Wishbone initiator (registered outputs)
// ---------------------------------------------------------------------------
module wb_copy_master
  import wb_copy_master_pkg::*;
#(
  parameter int LEN_W       = 16,
  parameter int TIMEOUT_CYC = DEFAULT_TIMEOUT
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_ni,
  input  logic             start_i,
  input  logic [31:0]      src_adr_i,
  input  logic [31:0]      dst_adr_i,
  input  logic [LEN_W-1:0] len_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             err_o,
  output logic             wbm_cyc_o,
  output logic             wbm_stb_o,
  output logic             wbm_we_o,
  output logic [3:0]       wbm_sel_o,
  output logic [31:0]      wbm_adr_o,
  output logic [31:0]      wbm_dat_o,
  input  logic [31:0]      wbm_dat_i,
  input  logic             wbm_ack_i
);

  // The counter is 8 bits wide; reject limits it cannot represent.
  if (TIMEOUT_CYC < 1 || TIMEOUT_CYC > 255) begin : g_bad_timeout
    $error("wb_copy_master: TIMEOUT_CYC must be in 1..255");
  end

  state_e           state_q, state_d;
  logic [31:0]      src_q, src_d;
  logic [31:0]      dst_q, dst_d;
  logic [31:0]      adr_q, adr_d;
  logic [31:0]      data_q, data_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic [3:0]       sel_q, sel_d;
  logic             cyc_q, cyc_d;
  logic             we_q, we_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             ack;
  logic             expired;

  // Only an ack that terminates a live bus cycle counts.
  assign ack = cyc_q & wbm_ack_i;

`ifdef WB_COPY_TIMEOUT_EN
  logic err_q;
  logic accept;

  assign accept = (state_q == ST_IDLE) && start_i;

  wb_copy_timer #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_timer (
    .clk    (wb_clk_i),
    .rst_n  (wb_rst_ni),
    .run    (cyc_q && !wbm_ack_i),
    .expired(expired)
  );

  // Sticky until the next accepted start.
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      err_q <= 1'b0;
    end else if (accept) begin
      err_q <= 1'b0;
    end else if (expired) begin
      err_q <= 1'b1;
    end
  end

  assign err_o = err_q;
`else
  assign expired = 1'b0;
  assign err_o   = 1'b0;
`endif

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state_q <= ST_IDLE;
      src_q   <= '0;
      dst_q   <= '0;
      adr_q   <= '0;
      data_q  <= '0;
      cnt_q   <= '0;
      sel_q   <= '0;
      cyc_q   <= 1'b0;
      we_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      adr_q   <= adr_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
      sel_q   <= sel_d;
      cyc_q   <= cyc_d;
      we_q    <= we_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // In RD/WR, cyc_q low marks the idle gap cycle that launches the next
  // bus cycle; cyc_q high means the cycle is waiting for ack.
  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    dst_d   = dst_q;
    adr_d   = adr_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    sel_d   = sel_q;
    cyc_d   = cyc_q;
    we_d    = we_q;
    busy_d  = busy_q;
    done_d  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          if (len_i != '0) begin
            src_d   = src_adr_i;
            dst_d   = dst_adr_i;
            cnt_d   = len_i;
            busy_d  = 1'b1;
            state_d = ST_RD;
          end else begin
            state_d = ST_DONE;
          end
        end
      end

      ST_RD: begin
        if (!cyc_q) begin
          cyc_d = 1'b1;
          we_d  = 1'b0;
          sel_d = SEL_ALL;
          adr_d = src_q;
        end else if (ack) begin
          data_d  = wbm_dat_i;
          cyc_d   = 1'b0;
          sel_d   = '0;
          state_d = ST_WR;
        end else if (expired) begin
          cyc_d   = 1'b0;
          sel_d   = '0;
          state_d = ST_ERR;
        end
      end

      ST_WR: begin
        if (!cyc_q) begin
          cyc_d = 1'b1;
          we_d  = 1'b1;
          sel_d = SEL_ALL;
          adr_d = dst_q;
        end else if (ack) begin
          cyc_d   = 1'b0;
          we_d    = 1'b0;
          sel_d   = '0;
          // 32-bit adders wrap naturally past 32'hFFFF_FFFC.
          src_d   = src_q + WORD_BYTES;
          dst_d   = dst_q + WORD_BYTES;
          cnt_d   = cnt_q - LEN_W'(1);
          state_d = (cnt_q == LEN_W'(1)) ? ST_DONE : ST_RD;
        end else if (expired) begin
          cyc_d   = 1'b0;
          we_d    = 1'b0;
          sel_d   = '0;
          state_d = ST_ERR;
        end
      end

      // done_o is registered, so it appears in the cycle after DONE/ERR,
      // together with busy_o falling.
      ST_DONE, ST_ERR: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign wbm_cyc_o = cyc_q;
  assign wbm_stb_o = cyc_q;
  assign wbm_we_o  = we_q;
  assign wbm_sel_o = sel_q;
  assign wbm_adr_o = adr_q;
  assign wbm_dat_o = data_q;
  assign busy_o    = busy_q;
  assign done_o    = done_q;

endmodule

// File: tb/tb_wb_copy_master.sv
// ---------------------------------------------------------------------------
// tb_wb_copy_master
// Self-checking bench for wb_copy_master. A Wishbone slave with a
// pseudo-random memory image answers the master; every copy is compared
// with the transaction list and latency predicted from the copy rules.
// Build with WB_COPY_TIMEOUT_EN to exercise the ack timeout.
// ---------------------------------------------------------------------------
module tb_wb_copy_master;

  localparam int LEN_W = 16;
  localparam int TMO   = 8;

  logic             clk = 1'b0;
  logic             rst_n = 1'b1;
  logic             start = 1'b0;
  logic [31:0]      src = '0;
  logic [31:0]      dst = '0;
  logic [LEN_W-1:0] len = '0;
  logic             busy, done, err;
  logic             cyc, stb, we;
  logic [3:0]       sel;
  logic [31:0]      adr, dat_o;
  logic [31:0]      dat_i = '0;
  logic             ack = 1'b0;

  always #5 clk = ~clk;

  wb_copy_master #(
    .LEN_W      (LEN_W),
    .TIMEOUT_CYC(TMO)
  ) dut (
    .wb_clk_i (clk),
    .wb_rst_ni(rst_n),
    .start_i  (start),
    .src_adr_i(src),
    .dst_adr_i(dst),
    .len_i    (len),
    .busy_o   (busy),
    .done_o   (done),
    .err_o    (err),
    .wbm_cyc_o(cyc),
    .wbm_stb_o(stb),
    .wbm_we_o (we),
    .wbm_sel_o(sel),
    .wbm_adr_o(adr),
    .wbm_dat_o(dat_o),
    .wbm_dat_i(dat_i),
    .wbm_ack_i(ack)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Memory image seen by the slave: a fixed scramble of the address.
  logic [31:0] seed;
  function automatic logic [31:0] mem_val(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ seed;
  endfunction

  // ---------------- Wishbone slave and bus monitor ----------------
  bit          ack_en   = 1'b1;
  bit          spurious = 1'b0;
  int          max_wait = 0;
  int          wait_cnt = 0, wait_req = 0, wait_total = 0;
  bit          pending  = 1'b0;
  bit          log_we[$];
  logic [31:0] log_adr[$];
  logic [31:0] log_dat[$];
  int          shape_err = 0, gap_err = 0;
  bit          gap_trk = 1'b0;
  int          gap_len = 0;

  always @(posedge clk) begin
    #1;
    ack   = 1'b0;
    dat_i = 32'hDEAD_BEEF;
    if (!rst_n) begin
      pending = 1'b0;
      gap_trk = 1'b0;
    end else begin
      if (done) gap_trk = 1'b0;
      if (cyc) begin
        if (stb !== 1'b1 || sel !== 4'hF) shape_err++;
        if (gap_trk) begin
          if (gap_len != 1) gap_err++;
          gap_trk = 1'b0;
        end
        if (ack_en) begin
          if (!pending) begin
            pending  = 1'b1;
            wait_cnt = 0;
            wait_req = $urandom_range(0, max_wait);
          end
          if (wait_cnt == wait_req) begin
            ack     = 1'b1;
            pending = 1'b0;
            if (!we) dat_i = mem_val(adr);
            log_we.push_back(we);
            log_adr.push_back(adr);
            log_dat.push_back(we ? dat_o : dat_i);
            gap_trk = 1'b1;
            gap_len = 0;
          end else begin
            wait_cnt++;
            wait_total++;
          end
        end
      end else begin
        pending = 1'b0;
        if (stb !== 1'b0) shape_err++;
        if (gap_trk) gap_len++;
        if (spurious && $urandom_range(0, 3) == 0) ack = 1'b1;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One copy: drive start, wait for done_o, compare against the model.
  task automatic run_copy(input logic [31:0] s, input logic [31:0] d, input int n,
                          input bit poke, input string tag);
    bit          e_we[$];
    logic [31:0] e_adr[$];
    logic [31:0] e_dat[$];
    int          t;
    bit          poked;
    poked = 1'b0;
    for (int i = 0; i < n; i++) begin
      logic [31:0] ra, wa;
      ra = s + 32'(i) * 32'd4;
      wa = d + 32'(i) * 32'd4;
      e_we.push_back(1'b0); e_adr.push_back(ra); e_dat.push_back(mem_val(ra));
      e_we.push_back(1'b1); e_adr.push_back(wa); e_dat.push_back(mem_val(ra));
    end
    log_we.delete(); log_adr.delete(); log_dat.delete();
    wait_total = 0;
    src   = s;
    dst   = d;
    len   = LEN_W'(n);
    start = 1'b1;
    tick();
    start = 1'b0;
    src   = $urandom;
    dst   = $urandom;
    len   = LEN_W'($urandom);
    t     = 1;
    check_val({tag, "_err_clear"}, 32'(err), 32'd0);
    if (n != 0) check_val({tag, "_busy_rise"}, 32'(busy), 32'd1);
    while (!done && t < 400) begin
      if (poke && !poked && cyc && we) begin
        start = 1'b1;
        src   = 32'h5555_0000;
        dst   = 32'h6666_0000;
        len   = LEN_W'(7);
        poked = 1'b1;
      end else begin
        start = 1'b0;
      end
      tick();
      t++;
    end
    start = 1'b0;
    check_val({tag, "_done"}, 32'(done), 32'd1);
    check_val({tag, "_latency"}, 32'(t), 32'(4 * n + 2 + wait_total));
    check_val({tag, "_busy_at_done"}, 32'(busy), 32'd0);
    tick();
    check_val({tag, "_done_pulse"}, 32'(done), 32'd0);
    check_val({tag, "_n_xfers"}, 32'(log_adr.size()), 32'(e_adr.size()));
    for (int i = 0; i < e_adr.size() && i < log_adr.size(); i++) begin
      check_val({tag, "_we"},  32'(log_we[i]), 32'(e_we[i]));
      check_val({tag, "_adr"}, log_adr[i], e_adr[i]);
      check_val({tag, "_dat"}, log_dat[i], e_dat[i]);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog sim_time_expired got=1 exp=0");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int extra;
    int k;
    int hi;
    logic [31:0] rs, rd;
    seed = $urandom;

    // Reset state
    #2 rst_n = 1'b0;
    #1;
    check_val("rst_cyc",  32'(cyc),   32'd0);
    check_val("rst_stb",  32'(stb),   32'd0);
    check_val("rst_we",   32'(we),    32'd0);
    check_val("rst_sel",  32'(sel),   32'd0);
    check_val("rst_adr",  adr,        32'd0);
    check_val("rst_dat",  dat_o,      32'd0);
    check_val("rst_busy", 32'(busy),  32'd0);
    check_val("rst_done", 32'(done),  32'd0);
    check_val("rst_err",  32'(err),   32'd0);
    repeat (3) tick();
    rst_n = 1'b1;
    tick();

    // Directed copies
    run_copy(32'h3000_0000, 32'h3800_0000, 3, 1'b0, "dir3");
    run_copy(32'h1234_5670, 32'h2000_0000, 0, 1'b0, "len0");
    run_copy(32'hFFFF_FFFC, 32'h4000_0000, 2, 1'b0, "wrap");
    if (log_adr.size() > 2) check_val("wrap_second_rd_adr", log_adr[2], 32'h0000_0000);
    run_copy(32'h0000_1000, 32'h0000_2000, 4, 1'b1, "poke");
    extra = 0;
    repeat (10) begin
      tick();
      if (done || cyc) extra++;
    end
    check_val("poke_no_second_copy", 32'(extra), 32'd0);

    // Randomized copies with slave wait states and stray acks
    spurious = 1'b1;
    repeat (8) begin
      max_wait = $urandom_range(0, 2);
      rs = $urandom & 32'hFFFF_FFFC;
      rd = $urandom & 32'hFFFF_FFFC;
      run_copy(rs, rd, $urandom_range(1, 6), 1'b0, "rnd");
      repeat ($urandom_range(0, 3)) tick();
    end
    spurious = 1'b0;
    max_wait = 0;

    // Reset while a read is on the bus
    src   = 32'h0000_8000;
    dst   = 32'h0000_9000;
    len   = LEN_W'(5);
    start = 1'b1;
    tick();
    start = 1'b0;
    k = 0;
    while (!(cyc && !we) && k < 20) begin
      tick();
      k++;
    end
    check_val("rst_mid_reached_rd", 32'(cyc && !we), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check_val("rst_mid_cyc",  32'(cyc),  32'd0);
    check_val("rst_mid_stb",  32'(stb),  32'd0);
    check_val("rst_mid_busy", 32'(busy), 32'd0);
    extra = 0;
    repeat (3) begin
      tick();
      if (done) extra++;
    end
    rst_n = 1'b1;
    repeat (6) begin
      tick();
      if (done || cyc || busy) extra++;
    end
    check_val("rst_mid_quiet", 32'(extra), 32'd0);
    run_copy(32'h0000_0040, 32'h0000_0080, 1, 1'b0, "post_rst");

`ifdef WB_COPY_TIMEOUT_EN
    // Slave never acks: copy must abort after TMO cycles
    ack_en = 1'b0;
    src    = 32'h0000_0100;
    dst    = 32'h0000_0200;
    len    = LEN_W'(2);
    start  = 1'b1;
    tick();
    start  = 1'b0;
    k = 0;
    while (!cyc && k < 10) begin
      tick();
      k++;
    end
    hi = 0;
    while (cyc && hi < 50) begin
      hi++;
      tick();
    end
    check_val("tmo_cyc_cycles", 32'(hi), 32'(TMO));
    check_val("tmo_err_set", 32'(err), 32'd1);
    tick();
    check_val("tmo_done", 32'(done), 32'd1);
    check_val("tmo_err_sticky", 32'(err), 32'd1);
    tick();
    check_val("tmo_done_pulse", 32'(done), 32'd0);
    ack_en = 1'b1;
    run_copy(32'h0000_0300, 32'h0000_0400, 2, 1'b0, "after_tmo");
`else
    // Without the timeout the master waits for ack indefinitely
    ack_en = 1'b0;
    src    = 32'h0000_0100;
    dst    = 32'h0000_0200;
    len    = LEN_W'(1);
    start  = 1'b1;
    tick();
    start  = 1'b0;
    extra  = 0;
    hi     = 0;
    repeat (300) begin
      tick();
      if (done) extra++;
      if (err) hi++;
    end
    check_val("hang_cyc_held", 32'(cyc), 32'd1);
    check_val("hang_no_done", 32'(extra), 32'd0);
    check_val("hang_no_err", 32'(hi), 32'd0);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    ack_en = 1'b1;
    run_copy(32'h0000_0300, 32'h0000_0400, 2, 1'b0, "after_hang");
`endif

    check_val("bus_shape", 32'(shape_err), 32'd0);
    check_val("gap_one_cycle", 32'(gap_err), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/wb_copy_master.md
WB_COPY_MASTER -- requirements
Module: wb_copy_master

Interface
REQ-001 SHALL have parameter LEN_W, default 16, width of the word-count input.
REQ-002 SHALL have parameter TIMEOUT_CYC, default 255, ack-wait limit in cycles (8-bit counter).
REQ-003 SHALL have port wb_clk_i  input  1  sole clock, all logic on rising edge.
REQ-004 SHALL have port wb_rst_ni  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have ports start_i (in, 1) to begin a copy, src_adr_i (in, 32) as the source byte address, dst_adr_i (in, 32) as the destination byte address, and len_i (in, LEN_W) as the word count.
REQ-006 SHALL have ports busy_o (out, 1) high while a copy runs, done_o (out, 1) one-cycle completion pulse, and err_o (out, 1) sticky timeout flag.
REQ-007 SHALL have Wishbone initiator ports wbm_cyc_o, wbm_stb_o and wbm_we_o (out, 1), wbm_sel_o (out, 4), wbm_adr_o (out, 32), wbm_dat_o (out, 32), wbm_dat_i (in, 32) and wbm_ack_i (in, 1).

Function
REQ-008 SHALL implement the states IDLE, RD, WR, DONE and ERR.
REQ-009 IDLE: start_i=1 with len_i!=0 SHALL latch src/dst/len, go to RD and assert busy_o the next cycle.
REQ-010 IDLE: start_i=1 with len_i=0 SHALL go to DONE with no bus cycle.
REQ-011 start_i outside IDLE SHALL be ignored, with no change to latched values.
REQ-012 RD: cyc=stb=1, we=0, sel=4'hF, adr=current src; on ack, SHALL capture wbm_dat_i into the data register and go to WR.
REQ-013 WR: cyc=stb=1, we=1, sel=4'hF, adr=current dst, dat_o=data register; on ack, SHALL add 4 to src and dst, decrement the remaining count, then go to DONE if the count reaches 0, else to RD.
REQ-014 cyc/stb SHALL drop for exactly one cycle between consecutive Wishbone cycles (classic single cycles, no bursts).
REQ-015 Address increments SHALL wrap modulo 2^32; 32'hFFFF_FFFC+4 = 32'h0.
REQ-016 Wishbone outputs SHALL be registered and held stable until ack; an ack outside RD/WR SHALL be ignored.
REQ-017 DONE: done_o=1 for one cycle, busy_o=0 the same cycle, then SHALL return to IDLE.
REQ-018 Words transferred SHALL equal len_i exactly; max len = 2^LEN_W-1.
REQ-019 Copy latency for N words with ack one cycle after stb SHALL be 4N+2 cycles from start_i to done_o.

Reset
REQ-020 Asserting wb_rst_ni SHALL drive state to IDLE and set all outputs, counters, addresses and err_o to 0 immediately.
REQ-021 Reset mid-transfer SHALL drop cyc/stb without waiting for ack; the partial copy is abandoned.
REQ-022 Release SHALL take effect on the first rising edge with wb_rst_ni=1.

Configuration
REQ-023 The macro WB_COPY_TIMEOUT_EN SHALL control the ack timeout.
REQ-024 Defined: in RD/WR, after TIMEOUT_CYC consecutive cycles without ack, SHALL drop cyc/stb, set err_o, go to ERR, pulse done_o one cycle, then go to IDLE; err_o SHALL clear on the next accepted start_i.
REQ-025 Not defined: no counter, the ERR state is unreachable, err_o is tied to 0, and the block waits indefinitely for ack.

Structure
REQ-026 A shared package SHALL hold the state enum, the word-size constant (4), the SEL_ALL constant (4'hF) and the default timeout.
REQ-027 One sub-module is natural, wb_copy_timer (the timeout counter), instantiated only under WB_COPY_TIMEOUT_EN; the rest SHALL be a single FSM plus datapath.

Verification
REQ-028 The bench SHALL cover the following directed scenarios.
- src=32'h3000_0000, dst=32'h3800_0000, len=3, ack 1 cycle after stb -> reads 3000_0000/04/08 and writes 3800_0000/04/08 carry the read data; done_o at cycle 14; busy_o low after.
- len=0 -> no cyc; done_o 2 cycles after start_i; err_o=0.
- src=32'hFFFF_FFFC, len=2 -> second read address 32'h0000_0000.
- start_i pulsed during WR of a len=4 copy -> ignored; exactly 4 reads and 4 writes; one done_o.
- wb_rst_ni low while stb=1 in RD -> cyc/stb/busy_o 0 in the same cycle; no done_o.
- WB_COPY_TIMEOUT_EN defined, TIMEOUT_CYC=8, no ack -> cyc drops after 8 cycles; err_o=1 and done_o pulses; next start_i clears err_o.
